// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg
// Shared definitions for the EX stage: ALU operation codes and operand
// forward-select codes. These must stay in step with the decoder and hazard
// unit, which produce these codes.
//
// Contents:
//   alu_op_e   - 4-bit ALU operation encoding (bit 3 selects SUB / SRA)
//   fwd_sel_e  - 2-bit operand forward select (register file / EX-MEM / MEM-WB)

package execute_stage_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int FWD_SEL_W = 2;

    // Encodings follow the RISC-V funct3 layout, with bit 3 as the funct7[5]
    // flag. This lets the decoder build the code with almost no logic.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD  = 4'b0000,
        ALU_OP_SLL  = 4'b0001,
        ALU_OP_SLT  = 4'b0010,
        ALU_OP_SLTU = 4'b0011,
        ALU_OP_XOR  = 4'b0100,
        ALU_OP_SRL  = 4'b0101,
        ALU_OP_OR   = 4'b0110,
        ALU_OP_AND  = 4'b0111,
        ALU_OP_SUB  = 4'b1000,
        ALU_OP_SRA  = 4'b1101
    } alu_op_e;

    // Code 11 is not produced by the hazard unit. It falls back to the
    // register-file value so a stray code cannot pick up a stale bypass.
    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_REG     = 2'b00,
        FWD_MEM     = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if
// Bundle of the ID/EX inputs and the EX results for the execute stage.
//
// Signals:
//   pc, data1/2, mem_forward1/2, wb_forward1/2, sel_forward1/2, immd,
//   alu_op, alu_src, branch, jump             - driven by ID/EX (master)
//   result, zero, write_data, branch_target,
//   take_branch and their *_q registered copies - driven by EX (slave)
//
// Modports:
//   master - the pipeline side that drives ID/EX and consumes results
//   slave  - the execute stage itself

interface execute_stage_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10
);

    logic [ADDR_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] data1;
    logic [WORD_SIZE-1:0] data2;
    logic [WORD_SIZE-1:0] mem_forward1;
    logic [WORD_SIZE-1:0] mem_forward2;
    logic [WORD_SIZE-1:0] wb_forward1;
    logic [WORD_SIZE-1:0] wb_forward2;
    logic [1:0]           sel_forward1;
    logic [1:0]           sel_forward2;
    logic [WORD_SIZE-1:0] immd;
    logic [3:0]           alu_op;
    logic                 alu_src;
    logic                 branch;
    logic                 jump;

    logic [WORD_SIZE-1:0] result;
    logic                 zero;
    logic [WORD_SIZE-1:0] write_data;
    logic [ADDR_SIZE-1:0] branch_target;
    logic                 take_branch;

    logic [WORD_SIZE-1:0] result_q;
    logic                 zero_q;
    logic [WORD_SIZE-1:0] write_data_q;
    logic [ADDR_SIZE-1:0] branch_target_q;
    logic                 take_branch_q;

    modport master (
        output pc, data1, data2, mem_forward1, mem_forward2,
               wb_forward1, wb_forward2, sel_forward1, sel_forward2,
               immd, alu_op, alu_src, branch, jump,
        input  result, zero, write_data, branch_target, take_branch,
               result_q, zero_q, write_data_q, branch_target_q, take_branch_q
    );

    modport slave (
        input  pc, data1, data2, mem_forward1, mem_forward2,
               wb_forward1, wb_forward2, sel_forward1, sel_forward2,
               immd, alu_op, alu_src, branch, jump,
        output result, zero, write_data, branch_target, take_branch,
               result_q, zero_q, write_data_q, branch_target_q, take_branch_q
    );

endinterface

// File: rtl/execute_stage_alu.sv
// execute_stage_alu
// Purely combinational integer ALU for the EX stage.
//
// Ports:
//   a, b    in  WORD_SIZE  operands (shifts use b[4:0] only)
//   alu_op  in  4          operation code (see execute_stage_pkg::alu_op_e)
//   result  out WORD_SIZE  operation result; unknown codes give 0
//   zero    out 1          result == 0

module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [3:0]           alu_op,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero
);

    logic [4:0] shamt;

    always_comb begin
        shamt  = b[4:0];
        result = '0;
        case (alu_op)
            ALU_OP_ADD:  result = a + b;
            ALU_OP_SUB:  result = a - b;
            ALU_OP_SLL:  result = a << shamt;
            ALU_OP_SRL:  result = a >> shamt;
            // SRA needs a signed left operand so that >>> fills with the sign bit.
            ALU_OP_SRA:  result = $signed(a) >>> shamt;
            ALU_OP_SLT:  result = ($signed(a) < $signed(b)) ? WORD_SIZE'(1) : '0;
            ALU_OP_SLTU: result = (a < b) ? WORD_SIZE'(1) : '0;
            ALU_OP_XOR:  result = a ^ b;
            ALU_OP_OR:   result = a | b;
            ALU_OP_AND:  result = a & b;
            default:     result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// Execute stage of the 32-bit RISC-V pipeline. It resolves operand
// forwarding, runs the ALU, and computes the PC-relative branch/jump target
// and the redirect decision. Results leave combinationally and are also
// captured in the EX/MEM register.
//
// Ports:
//   clk    in  pipeline clock
//   rst_n  in  asynchronous active-low reset (clears all *_q outputs)
//   bus    execute_stage_if.slave
//          inputs : pc, data1/2, mem_forward1/2, wb_forward1/2,
//                   sel_forward1/2, immd, alu_op, alu_src, branch, jump
//          outputs: result, zero, write_data, branch_target, take_branch
//                   (combinational) and *_q copies (registered)
//
// REG_SEL and NUM_REGS are not used inside this stage. They are kept so that
// every pipeline stage has the same parameter list.

module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    execute_stage_if.slave bus
);

    logic [WORD_SIZE-1:0] operand_a;
    logic [WORD_SIZE-1:0] fwd_rs2;
    logic [WORD_SIZE-1:0] operand_b;
    logic [ADDR_SIZE-1:0] imm_offset;
    logic [WORD_SIZE-1:0] alu_result;
    logic                 alu_zero;

    logic [WORD_SIZE-1:0] result_d,        result_q;
    logic                 zero_d,          zero_q;
    logic [WORD_SIZE-1:0] write_data_d,    write_data_q;
    logic [ADDR_SIZE-1:0] branch_target_d, branch_target_q;
    logic                 take_branch_d,   take_branch_q;

    // Operand forwarding. Each operand is selected on its own. Store data
    // always takes the forwarded rs2, even when the ALU uses the immediate.
    always_comb begin
        operand_a = bus.data1;
        case (bus.sel_forward1)
            FWD_MEM: operand_a = bus.mem_forward1;
            FWD_WB:  operand_a = bus.wb_forward1;
            default: operand_a = bus.data1;
        endcase

        fwd_rs2 = bus.data2;
        case (bus.sel_forward2)
            FWD_MEM: fwd_rs2 = bus.mem_forward2;
            FWD_WB:  fwd_rs2 = bus.wb_forward2;
            default: fwd_rs2 = bus.data2;
        endcase

        operand_b = bus.alu_src ? bus.immd : fwd_rs2;
    end

    execute_stage_alu #(
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .a      (operand_a),
        .b      (operand_b),
        .alu_op (bus.alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // The target is computed every cycle, whether or not the instruction
    // branches. The immediate counts in words, and every term is cut to
    // ADDR_SIZE bits, so the sum wraps around the instruction address space.
    always_comb begin
        imm_offset      = bus.immd[ADDR_SIZE-1:0] << 2;
        branch_target_d = bus.pc + imm_offset;
        result_d        = alu_result;
        zero_d          = alu_zero;
        write_data_d    = fwd_rs2;
        // The decoder encodes bne/blt etc. through its alu_op choice, so
        // here a conditional branch only needs "result is zero".
        take_branch_d   = bus.jump | (bus.branch & alu_zero);
    end

    // EX/MEM register. The stage has no stall or flush input: bubbles arrive
    // as NOP encodings, so every edge captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q        <= '0;
            zero_q          <= 1'b0;
            write_data_q    <= '0;
            branch_target_q <= '0;
            take_branch_q   <= 1'b0;
        end else begin
            result_q        <= result_d;
            zero_q          <= zero_d;
            write_data_q    <= write_data_d;
            branch_target_q <= branch_target_d;
            take_branch_q   <= take_branch_d;
        end
    end

    assign bus.result          = result_d;
    assign bus.zero            = zero_d;
    assign bus.write_data      = write_data_d;
    assign bus.branch_target   = branch_target_d;
    assign bus.take_branch     = take_branch_d;

    assign bus.result_q        = result_q;
    assign bus.zero_q          = zero_q;
    assign bus.write_data_q    = write_data_q;
    assign bus.branch_target_q = branch_target_q;
    assign bus.take_branch_q   = take_branch_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
// Directed bench for execute_stage. Inputs change on the falling clock edge.
// Combinational outputs are sampled 1 time unit later. Registered outputs are
// sampled 1 time unit after the rising edge.

module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    execute_stage_if #(.WORD_SIZE(32), .ADDR_SIZE(10)) bus ();

    execute_stage #(
        .WORD_SIZE (32),
        .NUM_REGS  (32),
        .ADDR_SIZE (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call is one counted comparison; a mismatch is reported and counted.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Clear every input to a NOP (pc 100, register operands, no branch),
    // then set the ALU op and the two register-file operands.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] d1,
                                 input logic [31:0] d2);
        bus.pc           = 10'd100;
        bus.data1        = d1;
        bus.data2        = d2;
        bus.mem_forward1 = 32'hBAD0_0001;
        bus.mem_forward2 = 32'hBAD0_0002;
        bus.wb_forward1  = 32'hBAD0_0003;
        bus.wb_forward2  = 32'hBAD0_0004;
        bus.sel_forward1 = FWD_REG;
        bus.sel_forward2 = FWD_REG;
        bus.immd         = 32'd0;
        bus.alu_op       = op;
        bus.alu_src      = 1'b0;
        bus.branch       = 1'b0;
        bus.jump         = 1'b0;
    endtask

    task automatic checkComb(input string tag, input logic [31:0] r, input logic z,
                             input logic [31:0] wd, input logic [9:0] t,
                             input logic tk);
        #1;
        checkOutput({tag, ".result"},        bus.result,               r);
        checkOutput({tag, ".zero"},          {31'd0, bus.zero},        {31'd0, z});
        checkOutput({tag, ".write_data"},    bus.write_data,           wd);
        checkOutput({tag, ".branch_target"}, {22'd0, bus.branch_target}, {22'd0, t});
        checkOutput({tag, ".take_branch"},   {31'd0, bus.take_branch}, {31'd0, tk});
    endtask

    task automatic checkRegs(input string tag, input logic [31:0] r, input logic z,
                             input logic [31:0] wd, input logic [9:0] t,
                             input logic tk);
        checkOutput({tag, ".result_q"},        bus.result_q,                 r);
        checkOutput({tag, ".zero_q"},          {31'd0, bus.zero_q},          {31'd0, z});
        checkOutput({tag, ".write_data_q"},    bus.write_data_q,             wd);
        checkOutput({tag, ".branch_target_q"}, {22'd0, bus.branch_target_q}, {22'd0, t});
        checkOutput({tag, ".take_branch_q"},   {31'd0, bus.take_branch_q},   {31'd0, tk});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(ALU_OP_ADD, 32'd10, 32'd5);

        // Reset state, including across a rising edge while reset is held.
        #2;
        checkRegs("reset", 32'd0, 1'b0, 32'd0, 10'd0, 1'b0);
        @(posedge clk); #1;
        checkRegs("reset_edge", 32'd0, 1'b0, 32'd0, 10'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ALU operations
        @(negedge clk); applyStimulus(ALU_OP_ADD, 32'd10, 32'd5);
        checkComb("add", 32'd15, 1'b0, 32'd5, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_SUB, 32'd255, 32'd255);
        checkComb("sub_zero", 32'd0, 1'b1, 32'd255, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1);
        checkComb("add_wrap", 32'd0, 1'b1, 32'd1, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_SRL, 32'hFEDC_BA98, 32'd24);
        checkComb("srl", 32'h0000_00FE, 1'b0, 32'd24, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_SRA, 32'hFEDC_BA98, 32'd24);
        checkComb("sra", 32'hFFFF_FFFE, 1'b0, 32'd24, 10'd100, 1'b0);

        // Only b[4:0] counts: 0x3F shifts by 31.
        @(negedge clk); applyStimulus(ALU_OP_SLL, 32'd1, 32'h0000_003F);
        checkComb("sll_shamt", 32'h8000_0000, 1'b0, 32'h3F, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checkComb("and", 32'hF000_F000, 1'b0, 32'hFF00_FF00, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
        checkComb("slt_neg", 32'd1, 1'b0, 32'd1, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        checkComb("sltu_big", 32'd0, 1'b1, 32'd1, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(4'b1111, 32'd5, 32'd3);
        checkComb("bad_op", 32'd0, 1'b1, 32'd3, 10'd100, 1'b0);

        // Forwarding
        @(negedge clk); applyStimulus(ALU_OP_SUB, 32'd324, 32'd999);
        bus.mem_forward2 = 32'd8; bus.sel_forward2 = FWD_MEM;
        checkComb("fwd_mem2_sub", 32'd316, 1'b0, 32'd8, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_SLT, 32'd77, 32'd5);
        bus.mem_forward1 = 32'd5; bus.sel_forward1 = FWD_MEM; bus.branch = 1'b1;
        checkComb("fwd_mem1_slt_br", 32'd0, 1'b1, 32'd5, 10'd100, 1'b1);

        @(negedge clk); applyStimulus(ALU_OP_SLTU, 32'h8111_1111, 32'd0);
        bus.mem_forward2 = 32'hA200_0000; bus.sel_forward2 = FWD_MEM; bus.branch = 1'b1;
        checkComb("fwd_sltu_br_nz", 32'd1, 1'b0, 32'hA200_0000, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_OR, 32'hDEAD_0000, 32'd1);
        bus.wb_forward1 = 32'h0F0F_0000; bus.wb_forward2 = 32'h0000_00F0;
        bus.sel_forward1 = FWD_WB; bus.sel_forward2 = FWD_WB;
        checkComb("fwd_wb_or", 32'h0F0F_00F0, 1'b0, 32'h0000_00F0, 10'd100, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_OR, 32'h0000_0F00, 32'h0000_000F);
        bus.sel_forward1 = FWD_REG_ALT; bus.sel_forward2 = FWD_REG_ALT;
        checkComb("fwd_11_reg", 32'h0000_0F0F, 1'b0, 32'h0000_000F, 10'd100, 1'b0);

        // Immediate operand; write_data still carries rs2
        @(negedge clk); applyStimulus(ALU_OP_ADD, 32'hFFFF_FFD1, 32'd12345);
        bus.immd = 32'd47; bus.alu_src = 1'b1;
        checkComb("imm_add", 32'd0, 1'b1, 32'd12345, 10'd288, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_XOR, 32'hA050_A050, 32'd7);
        bus.immd = 32'h462A_BC4F; bus.alu_src = 1'b1;
        checkComb("imm_xor", 32'hE67A_1C1F, 1'b0, 32'd7, 10'd416, 1'b0);

        // Targets and redirect
        @(negedge clk); applyStimulus(ALU_OP_ADD, 32'd1, 32'd1);
        bus.immd = 32'd16; bus.jump = 1'b1;
        checkComb("jump_target", 32'd2, 1'b0, 32'd1, 10'd164, 1'b1);

        @(negedge clk); applyStimulus(ALU_OP_ADD, 32'd0, 32'd0);
        bus.pc = 10'd1000; bus.immd = 32'd10;
        checkComb("target_wrap", 32'd0, 1'b1, 32'd0, 10'd16, 1'b0);

        @(negedge clk); applyStimulus(ALU_OP_ADD, 32'd3, 32'd4);
        bus.immd = 32'hFFFF_FFFC;
        checkComb("target_neg", 32'd7, 1'b0, 32'd4, 10'd84, 1'b0);

        // EX/MEM register capture
        @(negedge clk); applyStimulus(ALU_OP_ADD, 32'h1234_5678, 32'h1111_1111);
        bus.immd = 32'd16; bus.jump = 1'b1;
        checkComb("reg_vec", 32'h2345_6789, 1'b0, 32'h1111_1111, 10'd164, 1'b1);
        @(posedge clk); #1;
        checkRegs("reg_cap1", 32'h2345_6789, 1'b0, 32'h1111_1111, 10'd164, 1'b1);

        @(negedge clk); applyStimulus(ALU_OP_SUB, 32'd5, 32'd5);
        bus.branch = 1'b1;
        checkComb("reg_vec2", 32'd0, 1'b1, 32'd5, 10'd100, 1'b1);
        checkRegs("reg_hold", 32'h2345_6789, 1'b0, 32'h1111_1111, 10'd164, 1'b1);
        @(posedge clk); #1;
        checkRegs("reg_cap2", 32'd0, 1'b1, 32'd5, 10'd100, 1'b1);

        // Reset asserted between edges clears the register at once.
        #2; rst_n = 1'b0;
        #1;
        checkRegs("async_reset", 32'd0, 1'b0, 32'd0, 10'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
